timer_alarm: RTL

//  Consumer of the free-running 64-bit microsecond count. Holds a CPU-programmed
//  64-bit deadline and raises a level interrupt once us_count reaches it.

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_alarm.sv | 88 ++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL bit positions and alarm state encoding shared by the timer blocks
package timer_pkg;
  localparam logic [1:0] TMR_CMP_LO = 2'd0;
  localparam logic [1:0] TMR_CMP_HI = 2'd1;
  localparam logic [1:0] TMR_CTRL   = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_PER   = 1;
  localparam int CTRL_ACK   = 2;
  localparam int CTRL_FIRED = 4;
  localparam int CTRL_OVR   = 5;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_FIRED = 2'd2} state_t;
endpackage

// File: rtl/timer_alarm.sv
// timer_alarm: 64-bit deadline compare against us_count raising a level irq; TIMER_ALARM_PERIODIC_EN adds periodic reload
module timer_alarm
  import timer_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       us_count,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              irq
);
  state_t state, state_d;
  logic [63:0] cmp, cmp_d, cmp_reload;
  logic [31:0] shadow_lo, ctrl_rd, st_rd, rd_mux;
  logic en, committed, hit, overrun, periodic, reload, reload_over, fired;
  logic wr_lo, wr_hi, wr_ctrl, wr_st, ack, disarm;
  assign wr_lo   = wr_en && wr_addr == ADDR_W'(TMR_CMP_LO);
  assign wr_hi   = wr_en && wr_addr == ADDR_W'(TMR_CMP_HI);
  assign wr_ctrl = wr_en && wr_addr == ADDR_W'(TMR_CTRL);
  assign wr_st   = wr_en && wr_addr == ADDR_W'(TMR_STATUS);
  assign ack     = wr_ctrl && wr_data[CTRL_ACK];
  assign disarm  = wr_ctrl && !wr_data[CTRL_EN];
  assign fired   = state == ST_FIRED;
  assign irq     = fired;
`ifdef TIMER_ALARM_PERIODIC_EN
  logic [31:0] period;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      period   <= '0;
      periodic <= 1'b0;
    end else begin
      period   <= wr_st ? wr_data : period;
      periodic <= wr_ctrl ? wr_data[CTRL_PER] : periodic;
    end
  assign cmp_reload  = cmp + {32'd0, period};
  assign reload_over = cmp_reload <= us_count;
  assign ctrl_rd     = {26'd0, overrun, fired, 2'd0, periodic, en};
  assign st_rd       = period;
`else
  assign periodic    = 1'b0;
  assign cmp_reload  = cmp;
  assign reload_over = 1'b0;
  assign ctrl_rd     = {31'd0, en};
  assign st_rd       = {30'd0, overrun, fired} | {31'd0, wr_st & 1'b0};
`endif
  always_comb begin
    state_d = state;
    reload  = 1'b0;
    if (disarm) state_d = ST_IDLE;
    else if (state == ST_IDLE) state_d = en && committed ? ST_ARMED : ST_IDLE;
    else if (state == ST_ARMED) state_d = hit && !wr_hi ? ST_FIRED : ST_ARMED;
    else if (ack && periodic) begin
      reload  = 1'b1;
      state_d = reload_over ? ST_FIRED : ST_ARMED;
    end else if (ack) state_d = ST_IDLE;
  end
  assign cmp_d  = wr_hi ? {wr_data, shadow_lo} : reload ? cmp_reload : cmp;
  assign rd_mux = rd_addr == ADDR_W'(TMR_CMP_LO) ? cmp[31:0] :
                  rd_addr == ADDR_W'(TMR_CMP_HI) ? cmp[63:32] :
                  rd_addr == ADDR_W'(TMR_CTRL)   ? ctrl_rd : st_rd;
  // hit is only meaningful while ARMED; any commit flushes the stale pipelined result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmp       <= '0;
      shadow_lo <= '0;
      en        <= 1'b0;
      committed <= 1'b0;
      hit       <= 1'b0;
      overrun   <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= state_d;
      cmp       <= cmp_d;
      shadow_lo <= wr_lo ? wr_data : shadow_lo;
      en        <= wr_ctrl ? wr_data[CTRL_EN] : en;
      committed <= wr_hi || (committed && !disarm && !(state == ST_ARMED && state_d == ST_FIRED));
      hit       <= state == ST_ARMED && !wr_hi && us_count >= cmp;
      overrun   <= reload && reload_over ? 1'b1 : ack && fired ? 1'b0 : overrun;
      rd_data   <= rd_en ? rd_mux : rd_data;
    end
endmodule
